// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: state encoding, RV32M divide funct3 codes and default widths
// shared by the divide sequencer, its interface and its bench.
package div_sequencer_pkg;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

endpackage

// File: rtl/div_sequencer_if.sv
// div_sequencer_if: EX-stage handshake between the pipeline (master) and the
// divide sequencer (slave).
import div_sequencer_pkg::*;

interface div_sequencer_if #(
    parameter int XLEN = DIV_XLEN
);
    logic            start;
    logic [2:0]      funct3;
    logic            flush;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            stall_req;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, flush, op_a, op_b,
        input  stall_req, done, result
    );

    modport slave (
        input  start, funct3, flush, op_a, op_b,
        output stall_req, done, result
    );
endinterface

// File: rtl/div_sequencer_step.sv
// div_sequencer_step: one combinational restoring-division iteration on the
// shifted {rem, quo} pair.
module div_sequencer_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // rem < div always holds, so the trial difference fits and its MSB is the sign.
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, i_div};

    always_comb begin
        o_rem = w_shift[XLEN-1:0];
        o_quo = {i_quo[XLEN-2:0], 1'b0};
        if (!w_diff[XLEN]) begin
            o_rem = w_diff[XLEN-1:0];
            o_quo = {i_quo[XLEN-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer with stall request.
// Define DIV_RESULT_CACHE_EN to add a one-entry result cache (e.g. DIV then REM).
import div_sequencer_pkg::*;

module div_sequencer #(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = DIV_CNT_W
) (
    input logic            clk,
    input logic            rst,
    div_sequencer_if.slave bus
);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [XLEN-1:0]  r_rem, w_rem_next;
    logic [XLEN-1:0]  r_quo, w_quo_next;
    logic [XLEN-1:0]  r_div, w_div_next;
    logic [XLEN-1:0]  r_result, w_result_next;
    logic             r_sign_a, w_sign_a_next;
    logic             r_sign_q, w_sign_q_next;
    logic             r_sel_rem, w_sel_rem_next;

    logic             w_signed, w_is_rem, w_neg_a, w_neg_b;
    logic             w_launch, w_b_zero, w_ovf, w_hit;
    logic [XLEN-1:0]  w_abs_a, w_abs_b, w_step_rem, w_step_quo;
    logic [XLEN-1:0]  w_q_fix, w_r_fix, w_hit_result;

    assign w_signed = (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
    assign w_is_rem = (bus.funct3 == F3_REM) || (bus.funct3 == F3_REMU);
    assign w_neg_a  = w_signed && bus.op_a[XLEN-1];
    assign w_neg_b  = w_signed && bus.op_b[XLEN-1];
    assign w_abs_a  = w_neg_a ? -bus.op_a : bus.op_a;
    assign w_abs_b  = w_neg_b ? -bus.op_b : bus.op_b;
    assign w_b_zero = (bus.op_b == '0);
    assign w_ovf    = w_signed && (bus.op_a == MIN_INT) && (bus.op_b == '1);
    assign w_launch = bus.start && !bus.flush && (r_state == ST_IDLE);

    assign w_q_fix  = r_sign_q ? -r_quo : r_quo;
    assign w_r_fix  = r_sign_a ? -r_rem : r_rem;

    div_sequencer_step #(.XLEN(XLEN)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

`ifdef DIV_RESULT_CACHE_EN
    logic            r_c_valid, r_c_signed, r_op_signed;
    logic [XLEN-1:0] r_c_a, r_c_b, r_c_quo, r_c_rem, r_op_a, r_op_b;

    assign w_hit = r_c_valid && (r_c_a == bus.op_a) && (r_c_b == bus.op_b)
                   && (r_c_signed == w_signed);
    assign w_hit_result = w_is_rem ? r_c_rem : r_c_quo;

    // Raw operands are kept so the entry matches what the pipeline presents next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_valid   <= 1'b0;
            r_c_signed  <= 1'b0;
            r_c_a       <= '0;
            r_c_b       <= '0;
            r_c_quo     <= '0;
            r_c_rem     <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_signed <= 1'b0;
        end else begin
            if (w_launch) begin
                r_op_a      <= bus.op_a;
                r_op_b      <= bus.op_b;
                r_op_signed <= w_signed;
            end
            if ((r_state == ST_FIX) && !bus.flush) begin
                r_c_valid  <= 1'b1;
                r_c_a      <= r_op_a;
                r_c_b      <= r_op_b;
                r_c_signed <= r_op_signed;
                r_c_quo    <= w_q_fix;
                r_c_rem    <= w_r_fix;
            end
        end
    end
`else
    assign w_hit        = 1'b0;
    assign w_hit_result = '0;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_rem_next     = r_rem;
        w_quo_next     = r_quo;
        w_div_next     = r_div;
        w_result_next  = r_result;
        w_sign_a_next  = r_sign_a;
        w_sign_q_next  = r_sign_q;
        w_sel_rem_next = r_sel_rem;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_sel_rem_next = w_is_rem;
                    w_sign_a_next  = w_neg_a;
                    w_sign_q_next  = w_neg_a ^ w_neg_b;
                    w_div_next     = w_abs_b;
                    w_quo_next     = w_abs_a;
                    w_rem_next     = '0;
                    w_cnt_next     = CNT_W'(XLEN - 1);
                    if (w_b_zero) begin
                        w_state_next  = ST_DONE;
                        w_result_next = w_is_rem ? bus.op_a : '1;
                    end else if (w_ovf) begin
                        w_state_next  = ST_DONE;
                        w_result_next = w_is_rem ? '0 : MIN_INT;
                    end else if (w_hit) begin
                        w_state_next  = ST_DONE;
                        w_result_next = w_hit_result;
                    end else begin
                        w_state_next  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                w_rem_next = w_step_rem;
                w_quo_next = w_step_quo;
                w_cnt_next = r_cnt - CNT_W'(1);
                if (r_cnt == '0) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_result_next = r_sel_rem ? w_r_fix : w_q_fix;
                w_state_next  = ST_DONE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // A kill from MEM overrides any progress, including the result write in FIX.
        if (bus.flush) begin
            w_state_next  = ST_IDLE;
            w_result_next = r_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_result  <= '0;
            r_sign_a  <= 1'b0;
            r_sign_q  <= 1'b0;
            r_sel_rem <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_rem     <= w_rem_next;
            r_quo     <= w_quo_next;
            r_div     <= w_div_next;
            r_result  <= w_result_next;
            r_sign_a  <= w_sign_a_next;
            r_sign_q  <= w_sign_q_next;
            r_sel_rem <= w_sel_rem_next;
        end
    end

    assign bus.stall_req = w_launch || (r_state == ST_CALC) || (r_state == ST_FIX);
    assign bus.done      = (r_state == ST_DONE) && !bus.flush;
    assign bus.result    = r_result;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized and directed checks of div_sequencer against an
// arithmetic reference model; honours DIV_RESULT_CACHE_EN for expected latency.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif
    localparam int LONG_LAT = 34;
    localparam int MAX_WAIT = 80;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    // model of the one-entry cache: which operands a later op may reuse
    logic        m_cv;
    logic [31:0] m_ca, m_cb;
    logic        m_cs;

    div_sequencer_if #(.XLEN(32)) bus ();

    div_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!f3[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (is_special(f3, a, b)) return 1;
        if (CACHE_ON && m_cv && m_ca == a && m_cb == b && m_cs == !f3[0]) return 1;
        return LONG_LAT;
    endfunction

    function automatic void model_commit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!is_special(f3, a, b)) begin
            m_cv = 1'b1;
            m_ca = a;
            m_cb = b;
            m_cs = !f3[0];
        end
    endfunction

    // Launch an op (cycle 0 = first cycle start is high) and wait for done.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output int lat, output int stall_cnt,
                          output logic [31:0] res);
        lat = -1;
        stall_cnt = 0;
        res = '0;
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.flush  = 1'b0;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        for (int c = 0; c < MAX_WAIT; c++) begin
            if (scramble && c == 3) begin
                bus.funct3 = 3'($urandom_range(4, 7));
                bus.op_a   = $urandom();
                bus.op_b   = $urandom();
            end
            @(negedge clk);
            if (bus.stall_req === 1'b1) stall_cnt++;
            if (bus.done === 1'b1) begin
                lat = c;
                res = bus.result;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic release_start;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_checks++; if (bus.stall_req !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_req); end
        n_checks++; if (bus.result !== 32'd0) begin n_errors++; $display("FAIL reset_result: got %h want 0", bus.result); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_cv = 1'b0;
        $display("reset: done=%b stall=%b result=%h", bus.done, bus.stall_req, bus.result);
    endtask

    task automatic test_basic;
        int lat, sc;
        logic [31:0] res;
        run_op(F3_DIV, 32'd100, 32'd7, 1'b0, lat, sc, res);
        $display("basic DIV 100/7: result=%h lat=%0d stall_cycles=%0d", res, lat, sc);
        n_checks++; if (res !== 32'd14) begin n_errors++; $display("FAIL basic_result: got %h want 0000000e", res); end
        n_checks++; if (lat != LONG_LAT) begin n_errors++; $display("FAIL basic_latency: got %0d want %0d", lat, LONG_LAT); end
        n_checks++; if (sc != LONG_LAT) begin n_errors++; $display("FAIL basic_stall_cycles: got %0d want %0d", sc, LONG_LAT); end
        model_commit(F3_DIV, 32'd100, 32'd7);
        release_start();
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
        n_checks++; if (bus.stall_req !== 1'b0) begin n_errors++; $display("FAIL basic_idle_stall: got %b want 0", bus.stall_req); end
        n_checks++; if (bus.result !== 32'd14) begin n_errors++; $display("FAIL basic_result_hold: got %h want 0000000e", bus.result); end
    endtask

    task automatic test_cache;
        logic [2:0]  f3s [3] = '{F3_REM, F3_DIVU, F3_REMU};
        logic [31:0] want[3] = '{32'd2, 32'd14, 32'd2};
        int          lats[3] = '{(CACHE_ON ? 1 : LONG_LAT), LONG_LAT, (CACHE_ON ? 1 : LONG_LAT)};
        int lat, sc;
        logic [31:0] res;
        for (int i = 0; i < 3; i++) begin
            run_op(f3s[i], 32'd100, 32'd7, 1'b0, lat, sc, res);
            $display("cache f3=%b 100/7: result=%h lat=%0d", f3s[i], res, lat);
            n_checks++; if (res !== want[i]) begin n_errors++; $display("FAIL cache_result[%0d]: got %h want %h", i, res, want[i]); end
            n_checks++; if (lat != lats[i]) begin n_errors++; $display("FAIL cache_latency[%0d]: got %0d want %0d", i, lat, lats[i]); end
            n_checks++; if (sc != lats[i]) begin n_errors++; $display("FAIL cache_stall[%0d]: got %0d want %0d", i, sc, lats[i]); end
            model_commit(f3s[i], 32'd100, 32'd7);
            release_start();
        end
    endtask

    task automatic test_signed;
        logic [2:0]  f3s [3] = '{F3_DIV, F3_REM, F3_REMU};
        logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] want[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_0001};
        int lat, sc, el;
        logic [31:0] res;
        for (int i = 0; i < 3; i++) begin
            el = exp_lat(f3s[i], as[i], 32'd2);
            run_op(f3s[i], as[i], 32'd2, 1'b0, lat, sc, res);
            $display("signed f3=%b a=%h b=2: result=%h lat=%0d", f3s[i], as[i], res, lat);
            n_checks++; if (res !== want[i]) begin n_errors++; $display("FAIL signed_result[%0d]: got %h want %h", i, res, want[i]); end
            n_checks++; if (lat != el) begin n_errors++; $display("FAIL signed_latency[%0d]: got %0d want %0d", i, lat, el); end
            n_checks++; if (sc != el) begin n_errors++; $display("FAIL signed_stall[%0d]: got %0d want %0d", i, sc, el); end
            model_commit(f3s[i], as[i], 32'd2);
            release_start();
        end
    endtask

    task automatic test_special;
        logic [2:0]  f3s [6] = '{F3_DIVU, F3_REMU, F3_DIV, F3_REM, F3_REM, F3_DIV};
        logic [31:0] as  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] want[6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        int lat, sc;
        logic [31:0] res;
        for (int i = 0; i < 6; i++) begin
            run_op(f3s[i], as[i], bs[i], 1'b0, lat, sc, res);
            $display("special f3=%b a=%h b=%h: result=%h lat=%0d", f3s[i], as[i], bs[i], res, lat);
            n_checks++; if (res !== want[i]) begin n_errors++; $display("FAIL special_result[%0d]: got %h want %h", i, res, want[i]); end
            n_checks++; if (lat != 1) begin n_errors++; $display("FAIL special_latency[%0d]: got %0d want 1", i, lat); end
            n_checks++; if (sc != 1) begin n_errors++; $display("FAIL special_stall[%0d]: got %0d want 1", i, sc); end
            release_start();
        end
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic [31:0] a, b, want, res;
        int lat, sc, el;
        a = 32'd1;
        b = 32'd1;
        for (int i = 0; i < 16; i++) begin
            f3 = 3'($urandom_range(4, 7));
            if (i == 0 || $urandom_range(0, 2) != 0) begin
                a = $urandom();
                case ($urandom_range(0, 5))
                    0: b = 32'd0;
                    1: b = 32'hFFFF_FFFF;
                    2: b = 32'($urandom_range(1, 15));
                    3: begin a = 32'h8000_0000; b = $urandom(); end
                    default: b = $urandom() >> $urandom_range(0, 28);
                endcase
            end
            want = ref_result(f3, a, b);
            el   = exp_lat(f3, a, b);
            run_op(f3, a, b, i[0], lat, sc, res);
            $display("random %0d f3=%b a=%h b=%h: result=%h lat=%0d", i, f3, a, b, res, lat);
            n_checks++; if (res !== want) begin n_errors++; $display("FAIL random_result[%0d]: got %h want %h", i, res, want); end
            n_checks++; if (lat != el) begin n_errors++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, el); end
            n_checks++; if (sc != el) begin n_errors++; $display("FAIL random_stall[%0d]: got %0d want %0d", i, sc, el); end
            model_commit(f3, a, b);
            release_start();
        end
    endtask

    task automatic test_flush;
        int lat, sc, el, ndone;
        logic [31:0] res;
        // kill during CALC, then relaunch
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = F3_DIV; bus.op_a = 32'd5000; bus.op_b = 32'd7;
        ndone = 0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) bus.flush = 1'b1;
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        bus.flush = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        n_checks++; if (ndone != 0) begin n_errors++; $display("FAIL flush_calc_done_count: got %0d want 0", ndone); end
        n_checks++; if (bus.stall_req !== 1'b0) begin n_errors++; $display("FAIL flush_calc_stall: got %b want 0", bus.stall_req); end
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL flush_calc_done: got %b want 0", bus.done); end
        el = exp_lat(F3_DIV, 32'd9, 32'd3);
        run_op(F3_DIV, 32'd9, 32'd3, 1'b0, lat, sc, res);
        $display("flush relaunch DIV 9/3: result=%h lat=%0d", res, lat);
        n_checks++; if (res !== 32'd3) begin n_errors++; $display("FAIL flush_relaunch_result: got %h want 00000003", res); end
        n_checks++; if (lat != el) begin n_errors++; $display("FAIL flush_relaunch_latency: got %0d want %0d", lat, el); end
        model_commit(F3_DIV, 32'd9, 32'd3);
        release_start();
        // kill during FIX: result must keep the previous value
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = F3_DIV; bus.op_a = 32'd1000; bus.op_b = 32'd3;
        repeat (33) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.stall_req !== 1'b1) begin n_errors++; $display("FAIL flush_fix_stall: got %b want 1", bus.stall_req); end
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL flush_fix_done: got %b want 0", bus.done); end
        n_checks++; if (bus.result !== 32'd3) begin n_errors++; $display("FAIL flush_fix_result: got %h want 00000003", bus.result); end
        // start and flush together in IDLE: no launch
        @(posedge clk); #1;
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = F3_DIVU; bus.op_a = 32'd77; bus.op_b = 32'd0;
        @(negedge clk);
        n_checks++; if (bus.stall_req !== 1'b0) begin n_errors++; $display("FAIL flush_start_stall: got %b want 0", bus.stall_req); end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL flush_start_done: got %b want 0", bus.done); end
        n_checks++; if (bus.result !== 32'd3) begin n_errors++; $display("FAIL flush_start_result: got %h want 00000003", bus.result); end
        // kill in DONE suppresses the pulse
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = F3_DIVU; bus.op_a = 32'd5; bus.op_b = 32'd0;
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL flush_done_pulse: got %b want 0", bus.done); end
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL flush_done_after: got %b want 0", bus.done); end
        $display("flush scenarios: result=%h", bus.result);
    endtask

    task automatic test_back_to_back;
        int lat, sc, el;
        logic [31:0] res;
        logic [2:0]  f3s [3] = '{F3_DIV, F3_DIVU, F3_DIVU};
        logic [31:0] as  [3] = '{32'd100, 32'd81, 32'd81};
        logic [31:0] bs  [3] = '{32'd7, 32'd9, 32'd9};
        logic [31:0] want[3] = '{32'd14, 32'd9, 32'd9};
        // start is never dropped between launches
        for (int i = 0; i < 3; i++) begin
            el = exp_lat(f3s[i], as[i], bs[i]);
            run_op(f3s[i], as[i], bs[i], 1'b0, lat, sc, res);
            $display("b2b %0d f3=%b a=%h b=%h: result=%h lat=%0d", i, f3s[i], as[i], bs[i], res, lat);
            n_checks++; if (res !== want[i]) begin n_errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, res, want[i]); end
            n_checks++; if (lat != el) begin n_errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, el); end
            model_commit(f3s[i], as[i], bs[i]);
        end
        release_start();
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL b2b_single_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_reset_mid;
        int lat, sc;
        logic [31:0] res;
        run_op(F3_DIV, 32'd100, 32'd7, 1'b0, lat, sc, res);
        model_commit(F3_DIV, 32'd100, 32'd7);
        release_start();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = F3_DIV; bus.op_a = 32'd555; bus.op_b = 32'd5;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.stall_req !== 1'b1) begin n_errors++; $display("FAIL rstmid_busy: got %b want 1", bus.stall_req); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_cv = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.stall_req !== 1'b0) begin n_errors++; $display("FAIL rstmid_stall: got %b want 0", bus.stall_req); end
        n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
        n_checks++; if (bus.result !== 32'd0) begin n_errors++; $display("FAIL rstmid_result: got %h want 0", bus.result); end
        // the cache must have been emptied by the reset
        run_op(F3_REM, 32'd100, 32'd7, 1'b0, lat, sc, res);
        $display("post-reset REM 100/7: result=%h lat=%0d", res, lat);
        n_checks++; if (res !== 32'd2) begin n_errors++; $display("FAIL rstmid_rem_result: got %h want 00000002", res); end
        n_checks++; if (lat != LONG_LAT) begin n_errors++; $display("FAIL rstmid_rem_latency: got %0d want %0d", lat, LONG_LAT); end
        release_start();
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = F3_DIV;
        bus.op_a   = '0;
        bus.op_b   = '0;
        m_cv = 1'b0;
        m_ca = '0;
        m_cb = '0;
        m_cs = 1'b0;
        test_reset();
        test_basic();
        test_cache();
        test_signed();
        test_special();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
